// File: rtl/add_seq.sv
// add_seq -- multi-cycle adder/subtractor.
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock, rippling
// the carry between cycles through a register. Start/busy/done handshake.
//
// Parameters:
//   WIDTH    operand/result width, positive multiple of CHUNK
//   CHUNK    bits processed per cycle (NCH = WIDTH/CHUNK cycles per op)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, a, b, sub    request and operands, sampled while idle
//   busy                operation in progress
//   done                one-cycle pulse, result outputs valid
//   sum, carry          result and carry out of the MSB (sub: 1 = no borrow)
//   overflow            signed two's-complement overflow
// Configuration:
//   ADD_SEQ_SUB_EN      when defined, sub selects a-b; otherwise sub is ignored
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | one chunk per cycle, LSB chunk first

module add_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  // Operands are shifted right each cycle so the active chunk is always at
  // the bottom; the result is shifted in from the top.
  logic [WIDTH-1:0] a_r, b_r, res;
  logic [KW-1:0]    k;
  logic             c;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   t;
  logic [WIDTH-1:0] res_nx;
  logic             last;
  logic             c_msb_in;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

`ifdef ADD_SEQ_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_ld = b;
  assign c_ld = 1'b0;
`endif

  always_comb begin
    a_ch   = a_r[CHUNK-1:0];
    b_ch   = b_r[CHUNK-1:0];
    t      = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c};
    res_nx = (res >> CHUNK) | (WIDTH'(t[CHUNK-1:0]) << (WIDTH - CHUNK));
    last   = (k == KLAST);
    // Carry into a bit is recovered from its sum bit: c_in = s ^ a ^ b.
    c_msb_in = t[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res      <= '0;
      k        <= '0;
      c        <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b_ld;
            c   <= c_ld;
            k   <= '0;
          end
        end
        RUN: begin
          a_r <= a_r >> CHUNK;
          b_r <= b_r >> CHUNK;
          res <= res_nx;
          c   <= t[CHUNK];
          k   <= k + 1'b1;
          if (last) begin
            sum      <= res_nx;
            carry    <= t[CHUNK];
            overflow <= c_msb_in ^ t[CHUNK];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
module tb_add_seq;

`ifdef ADD_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16, sub16, busy16, done16, carry16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start4, sub4, busy4, done4, carry4, ovf4;
  logic [3:0]  a4, b4, sum4;

  add_seq dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16)
  );

  add_seq #(.WIDTH(4), .CHUNK(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(ovf4)
  );

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  res_t q16[$];
  res_t q4[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: integer arithmetic with a signed-sign rule.
  function automatic res_t model(input int w, input int a, input int b, input bit s);
    res_t r;
    int mask, bb, cin, full, sm;
    mask = (1 << w) - 1;
    bb   = (SUB_EN && s) ? (~b & mask) : b;
    cin  = (SUB_EN && s) ? 1 : 0;
    full = a + bb + cin;
    sm   = full & mask;
    r.sum   = 16'(sm);
    r.carry = ((full >> w) & 1) != 0;
    r.ovf   = (((a >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
              (((sm >> (w-1)) & 1) != ((a >> (w-1)) & 1));
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1) begin
      if (done16 === 1'b1) begin
        if (q16.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_done16: got done=1, expected no result pending (t=%0t)", $time);
        end else begin
          e = q16.pop_front();
          chk("sum16", 32'(sum16), 32'(e.sum));
          chk("carry16", 32'(carry16), 32'(e.carry));
          chk("ovf16", 32'(ovf16), 32'(e.ovf));
        end
      end
      if (done4 === 1'b1) begin
        if (q4.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_done4: got done=1, expected no result pending (t=%0t)", $time);
        end else begin
          e = q4.pop_front();
          chk("res4 {carry,ovf,sum}", {26'd0, carry4, ovf4, sum4}, {26'd0, e.carry, e.ovf, e.sum[3:0]});
        end
      end
    end
  end

  task automatic wait_done16(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done16 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input res_t e);
    int lat;
    @(negedge clk);
    a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
    q16.push_back(e);
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    chk("busy16_after_start", 32'(busy16), 32'd1);
    wait_done16(lat);
    chk("latency16", 32'(lat), 32'd4);
  endtask

  task automatic op4(input int a, input int b, input bit s);
    int lat;
    @(negedge clk);
    a4 = 4'(a); b4 = 4'(b); sub4 = s; start4 = 1'b1;
    q4.push_back(model(4, a, b, s));
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done4 === 1'b1) begin
        lat = i - 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency4", 32'(lat), 32'd2);
  endtask

  vec_t tbl[8];
  res_t e;
  int   lat1, lat2;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    if (SUB_EN) begin
      tbl[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[7] = '{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0};
    end else begin
      tbl[5] = '{16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0};
      tbl[6] = '{16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b0};
      tbl[7] = '{16'h0007, 16'h0007, 1'b1, 16'h000E, 1'b0, 1'b0};
    end

    // Reset with random inputs, including start.
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); start16 = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom); start4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    chk("rst_carry16", 32'(carry16), 32'd0);
    chk("rst_ovf16", 32'(ovf16), 32'd0);
    chk("rst_res4", {26'd0, busy4, done4, carry4, ovf4, sum4}, 32'd0);
    @(negedge clk);
    start16 = 1'b0; start4 = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'(busy16), 32'd0);

    // Table-driven operations on the 16-bit instance.
    for (int i = 0; i < 8; i++) begin
      e.sum = tbl[i].sum; e.carry = tbl[i].carry; e.ovf = tbl[i].ovf;
      op16(tbl[i].a, tbl[i].b, tbl[i].sub, e);
    end

    // Start held through the run: only 3+5 computed, 9+9 taken on the done cycle.
    @(negedge clk);
    a16 = 16'd3; b16 = 16'd5; sub16 = 1'b0; start16 = 1'b1;
    q16.push_back('{16'h0008, 1'b0, 1'b0});
    @(posedge clk); #1;
    a16 = 16'd9; b16 = 16'd9;
    wait_done16(lat1);
    chk("hs_latency1", 32'(lat1), 32'd4);
    q16.push_back('{16'h0012, 1'b0, 1'b0});
    lat2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("hs_done_one_cycle", 32'(done16), 32'd0);
        chk("hs_busy_second", 32'(busy16), 32'd1);
        start16 = 1'b0;
      end
      if (done16 === 1'b1) begin
        lat2 = i;
        break;
      end
    end
    chk("hs_done_spacing", 32'(lat2), 32'd5);

    // Reset during cycle 2 of a run aborts it with no done pulse.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0101; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_done", 32'(done16), 32'd0);
    chk("abort_sum", 32'(sum16), 32'd0);
    chk("abort_flags", {30'd0, carry16, ovf16}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_idle", 32'(busy16), 32'd0);
    e.sum = 16'h0002; e.carry = 1'b0; e.ovf = 1'b0;
    op16(16'h0001, 16'h0001, 1'b0, e);

    // Exhaustive on the 4-bit / 2-bit-chunk instance.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(x, y, s[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
